// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: a 2-cycle multiplier and a 1-bit/cycle restoring divider.
// The operands are latched when start is accepted in IDLE. The result is held until the next done.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL      = 3'd1,
    DIV_INIT = 3'd2,
    DIV_ITER = 3'd3,
    FIN      = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        f3_r;
  logic [XLEN-1:0]   a_r, b_r, rem_r, quo_r, div_r, result_r;
  logic [CW-1:0]     cnt_r;
  logic              busy_r, done_r;

  logic [2*XLEN-1:0] mul_a_s, mul_b_s, prod_s;
  logic              div_signed_s, div_zero_s, ovf_s, last_s, fits_s;
  logic              neg_q_s, neg_r_s;
  logic [XLEN-1:0]   special_s, a_mag_s, b_mag_s, rem_nxt_s, quo_nxt_s, div_res_s;
  logic [XLEN:0]     shift_s;

  // Operand extension for the multiplier; the low 2*XLEN bits of the product are correct for every sign mode
  always_comb begin
    mul_a_s = {{XLEN{(f3_r[1:0] != 2'b11) & a_r[XLEN-1]}}, a_r};
    mul_b_s = {{XLEN{(f3_r[1:0] == 2'b01) & b_r[XLEN-1]}}, b_r};
    prod_s  = mul_a_s * mul_b_s;
  end

  // Divide special cases, operand magnitudes and the single restoring step
  always_comb begin
    div_signed_s = ~f3_r[0];
    div_zero_s   = (b_r == {XLEN{1'b0}});
    ovf_s        = div_signed_s & (a_r == {1'b1, {(XLEN-1){1'b0}}}) & (b_r == {XLEN{1'b1}});
    special_s    = {XLEN{1'b0}};
    if (div_zero_s) begin
      special_s = f3_r[1] ? a_r : {XLEN{1'b1}};
    end else if (ovf_s) begin
      special_s = f3_r[1] ? {XLEN{1'b0}} : a_r;
    end else begin
      special_s = {XLEN{1'b0}};
    end
    a_mag_s   = (div_signed_s & a_r[XLEN-1]) ? -a_r : a_r;
    b_mag_s   = (div_signed_s & b_r[XLEN-1]) ? -b_r : b_r;
    shift_s   = {rem_r, quo_r[XLEN-1]};
    fits_s    = (shift_s >= {1'b0, div_r});
    rem_nxt_s = fits_s ? (shift_s[XLEN-1:0] - div_r) : shift_s[XLEN-1:0];
    quo_nxt_s = {quo_r[XLEN-2:0], fits_s};
    neg_q_s   = div_signed_s & (a_r[XLEN-1] ^ b_r[XLEN-1]);
    neg_r_s   = div_signed_s & a_r[XLEN-1];
    if (f3_r[1]) begin
      div_res_s = neg_r_s ? -rem_nxt_s : rem_nxt_s;
    end else begin
      div_res_s = neg_q_s ? -quo_nxt_s : quo_nxt_s;
    end
    last_s = (cnt_r == CW'(XLEN - 1));
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = funct3[2] ? DIV_INIT : MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL:      state_s = FIN;
      DIV_INIT: state_s = (div_zero_s | ovf_s) ? FIN : DIV_ITER;
      DIV_ITER: state_s = last_s ? FIN : DIV_ITER;
      FIN:      state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // State register, with busy/done registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE) && (state_s != FIN);
      done_r  <= (state_s == FIN);
    end
  end

  // Datapath registers; result only changes on the transition into FIN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_r     <= 3'd0;
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      rem_r    <= {XLEN{1'b0}};
      quo_r    <= {XLEN{1'b0}};
      div_r    <= {XLEN{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            f3_r <= funct3;
            a_r  <= a;
            b_r  <= b;
          end
        end
        MUL: begin
          result_r <= (f3_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
        DIV_INIT: begin
          if (div_zero_s | ovf_s) begin
            result_r <= special_s;
          end else begin
            rem_r <= {XLEN{1'b0}};
            quo_r <= a_mag_s;
            div_r <= b_mag_s;
            cnt_r <= {CW{1'b0}};
          end
        end
        DIV_ITER: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            result_r <= div_res_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes model results and the monitor checks them on done.
module tb_muldiv_unit;

  logic        clk, rst_n, start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb_q[$];
  int   cyc       = 0;
  int   n_vec     = 0;
  int   n_err     = 0;
  int   busy_cnt  = 0;
  int   done_seen = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: RV32M semantics in plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] ux, uy, p;
    int          ix, iy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    ix = $signed(x);
    iy = $signed(y);
    case (f3)
      3'd0: begin p = ux * uy;             return p[31:0];  end
      3'd1: begin p = $unsigned(sx * sy);  return p[63:32]; end
      3'd2: begin p = $unsigned(sx) * uy;  return p[63:32]; end
      3'd3: begin p = ux * uy;             return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(ix / iy);
      end
      3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ix % iy);
      end
      3'd7: return (y == 32'd0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    if (!f3[2]) return 2;
    if (y == 32'd0) return 2;
    if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Monitor: pops the scoreboard on every done and checks result, latency and busy length
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else if (done) begin
        done_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", result, e.res);
          check("latency", 32'(cyc - e.t0), 32'(e.lat));
          check("busy_cycles", 32'(busy_cnt), 32'(e.lat - 1));
        end
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end
    end
  end

  // Called at a negedge in an IDLE cycle; start is held for exactly one edge
  task automatic issue(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.res = ref_result(f3, x, y);
    e.lat = ref_lat(f3, x, y);
    e.t0  = cyc;
    sb_q.push_back(e);
    start  = 1'b1;
    funct3 = f3;
    a      = x;
    b      = y;
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    a      = $urandom;
    b      = $urandom;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      sb_q.delete();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    issue(f3, x, y);
    wait_done();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ds;
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2);
    run_op(3'd4, 32'd100,        32'hFFFF_FFF9);
    run_op(3'd6, 32'd100,        32'hFFFF_FFF9);
    run_op(3'd5, 32'd100,        32'd7);
    run_op(3'd7, 32'd100,        32'd7);
    run_op(3'd5, 32'h1234,       32'd0);
    run_op(3'd6, 32'h1234,       32'd0);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick());
    end

    // A start pulse mid-divide must be ignored
    issue(3'd4, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    a      = 32'd5;
    b      = 32'd6;
    @(negedge clk);
    start  = 1'b0;
    wait_done();

    // Reset around iteration 10 aborts the divide without a done
    issue(3'd5, 32'hDEAD_BEEF, 32'd13);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    rst_n = 1'b1;
    ds = done_seen;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_seen - ds), 32'd0);
    run_op(3'd0, 32'd12345, 32'd678);

    repeat (5) @(negedge clk);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
